pru_cmd_queue: RTL
==================

PRU_CMD_QUEUE -- requirements
Module: pru_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO entries; SHALL be a power of 2, at least 2.
REQ-002 Parameter TIMEOUT, default 255, meaning idle cycles allowed between word0 and word1; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 write  in  1  word strobe from host; data valid while high.
REQ-006 data  in  32  command word; word0/word1 alternate.
REQ-007 flush  in  1  synchronous clear of FIFO and partial command.
REQ-008 ack  out  1  combinational; word accepted this cycle.
REQ-009 out_valid  out  1  head command available (= !empty).
REQ-010 out_ready  in  1  consumer pops head when out_valid && out_ready.
REQ-011 color[1:0], row[9:0], col[8:0], width[9:0], height_radius[8:0], shape_select[1:0]  out  head command fields.
REQ-012 start, subtract, color_load, VGA_CTRL_CLK, VGA_Read  out  1 each  head command flags.
REQ-013 level  out  $clog2(DEPTH)+1  FIFO occupancy; full, empty  out  1 each.
REQ-014 err_timeout  out  1  one-cycle pulse when a partial command is discarded.

Function
REQ-015 Word0 field map: color=data[1:0], row=[11:2], col=[20:12], width=[30:21]; data[31] ignored.
REQ-016 Word1 field map: height_radius=[8:0], shape_select=[10:9], start=[11], subtract=[12], color_load=[13], VGA_CTRL_CLK=[14], VGA_Read=[15]; data[31:16] ignored.
REQ-017 FSM states: IDLE (expect word0) and HALF (word0 staged); reset and flush enter IDLE.
REQ-018 IDLE: write -> ack=1, word0 latched into staging, go HALF.
REQ-019 HALF: write && !full -> ack=1, {staging, word1} pushed, go IDLE; write && full -> ack=0, stay HALF, data not taken.
REQ-020 Push when full is refused even if a pop occurs the same cycle.
REQ-021 Push into empty FIFO: out_valid and fields valid on the cycle after the word1 ack edge (1-cycle latency).
REQ-022 Fields show the FIFO head (show-ahead); all field/flag outputs SHALL be 0 while empty.
REQ-023 Simultaneous push and pop when not full: level unchanged, order preserved.
REQ-024 Pointers wrap modulo DEPTH; level ranges 0..DEPTH; full = (level==DEPTH), empty = (level==0).
REQ-025 Timeout: in HALF, counter increments each cycle without write; on reaching TIMEOUT, staging discarded, err_timeout pulses, go IDLE; counter cleared on entry to HALF.
REQ-026 flush has priority over write and pop: ack=0 that cycle, FIFO emptied, staging discarded, no err_timeout.
REQ-027 Pop when empty has no effect.

Reset
REQ-028 rst_n low asynchronously clears: state=IDLE, pointers/level=0, staging=0, timeout counter=0, err_timeout=0, all field outputs 0, out_valid=0, empty=1, full=0.
REQ-029 Reset mid-command (HALF) SHALL discard word0; the next word after reset is treated as word0.

Configuration
REQ-030 Macro PRU_CMD_QUEUE_STATS_EN defined: adds outputs cmd_count[15:0] (increments per pop, wraps 0xFFFF->0) and drop_count[7:0] (increments per timeout discard, saturates at 0xFF); both reset to 0 and are not cleared by flush.
REQ-031 Macro undefined: those ports and counters are absent; all other behaviour identical.

Verification
REQ-032 Basic: write 0x00803016 then 0x00000A0A, out_ready=0 -> next cycle out_valid=1, color=2, row=5, col=3, width=4, height_radius=10, shape_select=1, start=1, level=1.
REQ-033 Full/backpressure: DEPTH=4, push 4 commands, then word0 acked, word1 -> ack=0 with full=1; raise out_ready one cycle -> next word1 ack=1, FIFO order intact.
REQ-034 Timeout: TIMEOUT=8, word0 then no write 8 cycles -> err_timeout pulses once, FSM IDLE; next write treated as word0, level stays 0.
REQ-035 Flush: 3 commands queued plus word0 staged, flush=1 with write=1 -> ack=0, level=0, empty=1, fields 0, no err_timeout.
REQ-036 Async reset: assert rst_n low mid-cycle while in HALF with level=2 -> outputs 0 immediately; after release, two-word command round-trips correctly.
REQ-037 STATS_EN: 3 pops and 1 timeout -> cmd_count=3, drop_count=1; flush leaves both unchanged.

Source files
------------

// File: rtl/pru_cmd_queue.sv
// pru_cmd_queue: assembles two-word host commands into a show-ahead FIFO.
//   clk, rst_n          single rising-edge clock, async active-low reset
//   write, data         host word strobe / 32-bit word (word0 then word1)
//   flush               synchronous clear of FIFO and any staged word0
//   ack                 combinational: current word accepted this cycle
//   out_valid/out_ready head command handshake (pop on valid && ready)
//   color..VGA_Read     head command fields/flags, all zero while empty
//   level, full, empty  FIFO occupancy
//   err_timeout         one-cycle pulse when a staged word0 is discarded
// Optional feature macro PRU_CMD_QUEUE_STATS_EN adds cmd_count (pops, wraps)
// and drop_count (timeout discards, saturates); neither is cleared by flush.
module pru_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  logic [31:0]              data,
  input  logic                     flush,
  output logic                     ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               color,
  output logic [9:0]               row,
  output logic [8:0]               col,
  output logic [9:0]               width,
  output logic [8:0]               height_radius,
  output logic [1:0]               shape_select,
  output logic                     start,
  output logic                     subtract,
  output logic                     color_load,
  output logic                     VGA_CTRL_CLK,
  output logic                     VGA_Read,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     err_timeout
`ifdef PRU_CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]              cmd_count,
  output logic [7:0]               drop_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned EW = 47;  // word1[15:0] above word0[30:0]
  localparam bit          TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1'b1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HALF = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [30:0]     stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head_s;
  logic            full_s, empty_s;
  logic            ack_s, load_s, push_s, pop_s, timeout_s;
  logic            unused_data_s;

  assign full_s        = (level_q == LVL_FULL);
  assign empty_s       = (level_q == {LW{1'b0}});
  assign pop_s         = !flush && !empty_s && out_ready;
  assign unused_data_s = data[31];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: flush wins, word1 push or timeout returns to IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = write ? ST_HALF : ST_IDLE;
        ST_HALF: state_d = (push_s || timeout_s) ? ST_IDLE : ST_HALF;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: accept strobe, word0 load, command push, timeout discard
  always_comb begin
    ack_s     = 1'b0;
    load_s    = 1'b0;
    push_s    = 1'b0;
    timeout_s = 1'b0;
    if (flush) begin
      ack_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_s  = write;
          load_s = write;
        end
        ST_HALF: begin
          // A full FIFO refuses word1 even if the head is popped this cycle
          if (write) begin
            ack_s  = !full_s;
            push_s = !full_s;
          end else begin
            timeout_s = TO_EN && (cnt_q == TO_LAST);
          end
        end
        default: ack_s = 1'b0;
      endcase
    end
  end

  // Staging, idle counter and error pulse next-state
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    err_d   = timeout_s;
    if (flush || timeout_s) begin
      stage_d = 31'd0;
    end else if (load_s) begin
      stage_d = data[30:0];
    end else begin
      stage_d = stage_q;
    end
    if (flush || load_s || push_s || timeout_s) begin
      cnt_d = {CW{1'b0}};
    end else if (TO_EN && (state_q == ST_HALF) && !write) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Staging, idle counter and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 31'd0;
      cnt_q   <= {CW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // FIFO pointers, occupancy and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {data[15:0], stage_q};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head fields are forced to zero while the FIFO is empty
  assign head_s = empty_s ? {EW{1'b0}} : mem_q[rd_ptr_q];

  assign ack           = ack_s;
  assign out_valid     = !empty_s;
  assign level         = level_q;
  assign full          = full_s;
  assign empty         = empty_s;
  assign err_timeout   = err_q;
  assign color         = head_s[1:0];
  assign row           = head_s[11:2];
  assign col           = head_s[20:12];
  assign width         = head_s[30:21];
  assign height_radius = head_s[39:31];
  assign shape_select  = head_s[41:40];
  assign start         = head_s[42];
  assign subtract      = head_s[43];
  assign color_load    = head_s[44];
  assign VGA_CTRL_CLK  = head_s[45];
  assign VGA_Read      = head_s[46];

`ifdef PRU_CMD_QUEUE_STATS_EN
  logic [15:0] cmd_cnt_q;
  logic [7:0]  drop_cnt_q;

  // Statistics: pops wrap, timeout drops saturate; flush leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt_q  <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (pop_s) begin
        cmd_cnt_q <= cmd_cnt_q + 16'd1;
      end
      if (timeout_s && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign cmd_count  = cmd_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule
